// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream program loader. It assembles a 32-bit length header
//               and N instruction words, writes the words into the core's
//               instruction memory, then holds the core's run enable high.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W    = 19,
    parameter int MAX_WORDS = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              reload,
    output logic [31:0]       o_instruction,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_wea,
    output logic              o_start,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] word_cnt
);

    localparam int                c_CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] c_ST_LEN   = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_FLUSH = 3'd2;
    localparam logic [2:0] c_ST_RUN   = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    // The whole program image must be addressable without wrapping onto itself.
    if ((longint'(BASE_ADDR) + longint'(MAX_WORDS) - 1) >= (longint'(1) << ADDR_W)
        || MAX_WORDS < 1) begin : g_param_check
        $error("imem_loader: BASE_ADDR + MAX_WORDS - 1 does not fit in ADDR_W bits");
    end

    logic [2:0]         r_state;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_shift;
    logic [c_CNT_W-1:0] r_len;
    logic [c_CNT_W-1:0] r_widx;
    logic [31:0]        r_instr;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_wea;
    logic [ADDR_W-1:0]  r_word_cnt;
    logic               r_start;
    logic               r_err;
    logic               r_busy;
    logic               r_ready;

    logic               w_xfer;
    logic               w_word_done;
    logic [31:0]        w_word;
    logic               w_hdr_bad;
    logic               w_last;
    logic [c_CNT_W-1:0] w_widx_inc;
    logic [2:0]         w_state_nxt;

    always_comb begin
        w_xfer      = s_valid & r_ready;
        w_word_done = w_xfer && (r_byte_cnt == 2'd3);
        w_word      = {s_data, r_shift};
        w_hdr_bad   = (w_word == 32'd0) || (w_word > 32'(MAX_WORDS));
        w_last      = (r_widx == r_len - c_CNT_W'(1));
        w_widx_inc  = r_widx + c_CNT_W'(1);

        w_state_nxt = r_state;
        if (reload) begin
            w_state_nxt = c_ST_LEN;
        end else begin
            case (r_state)
                c_ST_LEN:   if (w_word_done) w_state_nxt = w_hdr_bad ? c_ST_ERR : c_ST_LOAD;
                c_ST_LOAD:  if (w_word_done && w_last) w_state_nxt = c_ST_FLUSH;
                c_ST_FLUSH: w_state_nxt = c_ST_RUN;
                c_ST_RUN:   w_state_nxt = c_ST_RUN;
                c_ST_ERR:   w_state_nxt = c_ST_ERR;
                default:    w_state_nxt = c_ST_LEN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_LEN;
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_len      <= '0;
            r_widx     <= '0;
            r_instr    <= 32'd0;
            r_addr     <= '0;
            r_wea      <= 1'b0;
            r_word_cnt <= '0;
            r_start    <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_wea   <= 1'b0;
            r_start <= (w_state_nxt == c_ST_RUN);
            r_err   <= (w_state_nxt == c_ST_ERR);
            r_busy  <= (w_state_nxt == c_ST_LEN) || (w_state_nxt == c_ST_LOAD)
                       || (w_state_nxt == c_ST_FLUSH);
            r_ready <= (w_state_nxt == c_ST_LEN) || (w_state_nxt == c_ST_LOAD);

            if (reload) begin
                // Drops any partial word and suppresses a write that would land next cycle.
                r_byte_cnt <= 2'd0;
                r_shift    <= 24'd0;
                r_widx     <= '0;
                r_word_cnt <= '0;
            end else if (w_xfer) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_shift    <= {s_data, r_shift[23:8]};
                if (w_word_done) begin
                    if (r_state == c_ST_LEN) begin
                        if (!w_hdr_bad) r_len <= w_word[c_CNT_W-1:0];
                        r_widx     <= '0;
                        r_word_cnt <= '0;
                    end else if (r_state == c_ST_LOAD) begin
                        r_wea      <= 1'b1;
                        r_instr    <= w_word;
                        r_addr     <= c_BASE + ADDR_W'(r_widx);
                        r_word_cnt <= ADDR_W'(w_widx_inc);
                        r_widx     <= w_widx_inc;
                    end
                end
            end
        end
    end

    assign s_ready       = r_ready;
    assign o_instruction = r_instr;
    assign o_addr        = r_addr;
    assign o_wea         = r_wea;
    assign o_start       = r_start;
    assign busy          = r_busy;
    assign err           = r_err;
    assign word_cnt      = r_word_cnt;

endmodule
`default_nettype wire
